// File: rtl/aurora_pkg.sv
// aurora_pkg: shared lane types, ordered sets and TX scheduler constants
package aurora_pkg;

    localparam int AXI_DATA_SIZE = 32;

    localparam int CC_PERIOD_DEF = 10000;
    localparam int CC_LEN_DEF    = 3;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CC   = 2'd1
    } ordered_sets_e;

    typedef logic [1:0] tx_sched_state_e;

    localparam tx_sched_state_e ST_DOWN = 2'd0;
    localparam tx_sched_state_e ST_RUN  = 2'd1;
    localparam tx_sched_state_e ST_CC   = 2'd2;

endpackage

// File: rtl/cc_timer.sv
// cc_timer: counts RUN cycles up to a CC insertion and the length of each insertion
module cc_timer #(
    parameter int CC_PERIOD = 16,
    parameter int CC_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    input  logic cc_i,
    output logic cc_due_o,
    output logic cc_done_o
);

    localparam int W_CC  = $clog2(CC_PERIOD);
    localparam int W_LEN = CC_LEN > 1 ? $clog2(CC_LEN) : 1;
    localparam logic [W_CC-1:0]  CC_LAST  = W_CC'(CC_PERIOD - 1);
    localparam logic [W_LEN-1:0] LEN_LAST = W_LEN'(CC_LEN - 1);

    logic [W_CC-1:0]  cc_cnt_q, cc_cnt_d;
    logic [W_LEN-1:0] len_cnt_q, len_cnt_d;

    assign cc_due_o  = run_i && (cc_cnt_q == CC_LAST);
    assign cc_done_o = cc_i && (len_cnt_q == LEN_LAST);

    // Period counter runs only in RUN, restarts on insertion or link loss; length counter runs only in CC
    always_comb begin
        cc_cnt_d  = clr_i ? '0 : run_i ? (cc_due_o ? '0 : cc_cnt_q + 1'b1) : cc_cnt_q;
        len_cnt_d = (cc_i && !cc_done_o) ? len_cnt_q + 1'b1 : '0;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_cnt_q  <= '0;
            len_cnt_q <= '0;
        end else begin
            cc_cnt_q  <= cc_cnt_d;
            len_cnt_q <= len_cnt_d;
        end
    end

endmodule

// File: rtl/tx_cc_scheduler.sv
// tx_cc_scheduler: gates user TX beats on link state and steals the lane for periodic CC sequences
module tx_cc_scheduler
    import aurora_pkg::*;
#(
    parameter int CC_PERIOD = CC_PERIOD_DEF,
    parameter int CC_LEN    = CC_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     channel_up,
    input  logic                     s_axi_valid,
    input  logic                     s_axi_last,
    input  logic [AXI_DATA_SIZE-1:0] s_axi_data,
    output logic                     s_axi_ready,
    output logic                     m_axi_valid,
    output logic                     m_axi_last,
    output logic [AXI_DATA_SIZE-1:0] m_axi_data,
    output ordered_sets_e            os_override,
    output logic                     frame_abort
);

    tx_sched_state_e state_q, state_d;
    logic            cc_due, cc_done, xfer;
    logic            in_frame_q;

    cc_timer #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) u_cc_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!channel_up || state_q == ST_DOWN),
        .run_i     (state_q == ST_RUN),
        .cc_i      (state_q == ST_CC),
        .cc_due_o  (cc_due),
        .cc_done_o (cc_done)
    );

    assign s_axi_ready = (state_q == ST_RUN) && !cc_due && channel_up;
    assign xfer        = s_axi_valid && s_axi_ready;

    // Link loss overrides everything, including an insertion already in progress
    always_comb begin
        state_d = !channel_up           ? ST_DOWN :
                  state_q == ST_DOWN    ? ST_RUN :
                  state_q == ST_RUN     ? (cc_due ? ST_CC : ST_RUN) :
                  cc_done               ? ST_RUN : ST_CC;
    end

    // State, output stage and frame tracking; os_override lines up with the m_* stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DOWN;
            m_axi_valid <= 1'b0;
            m_axi_last  <= 1'b0;
            m_axi_data  <= '0;
            os_override <= NONE;
            frame_abort <= 1'b0;
            in_frame_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_axi_valid <= xfer;
            m_axi_last  <= xfer && s_axi_last;
            m_axi_data  <= xfer ? s_axi_data : m_axi_data;
            os_override <= (state_d == ST_CC) ? CC : NONE;
            frame_abort <= !channel_up && in_frame_q;
            in_frame_q  <= !channel_up ? 1'b0 : xfer ? !s_axi_last : in_frame_q;
        end
    end

endmodule
